seq_divider_32by16: RTL and testbench

//   Iterative restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient + DW-bit remainder.

---
 rtl/seq_divider_32by16_pkg.sv | 19 +
 rtl/seq_divider_32by16_if.sv | 33 +++
 rtl/seq_divider_32by16_div_restore_step.sv | 33 +++
 rtl/seq_divider_32by16.sv | 147 ++++++++++++++
 tb/tb_seq_divider_32by16.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_32by16_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DW_DEFAULT  : default divisor/quotient/remainder width (dividend is 2*DW)
//   div_state_t : controller states, 2-bit encoding
//   iter_count  : number of restoring iterations for a given width/truncation
package seq_divider_32by16_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic int iter_count(input int dw, input int skip_lsb);
    return dw - skip_lsb;
  endfunction

endpackage

// File: rtl/seq_divider_32by16_if.sv
// Operand/result handshake bundle for seq_divider_32by16.
//   in_valid/in_ready    : operand handshake (dividend 2*DW bits, divisor DW bits)
//   out_valid/out_ready  : result handshake (quotient, remainder, div_by_zero, overflow)
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : divider side
interface seq_divider_32by16_if
  import seq_divider_32by16_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_32by16_div_restore_step.sv
// One combinational restoring-division step.
//   r_in     [DW:0] : partial remainder entering the step (always < divisor)
//   next_bit        : next dividend bit shifted in
//   divisor  [DW-1:0]
//   r_next   [DW:0] : partial remainder after the step
//   q_bit           : quotient bit produced by the step
module div_restore_step
  import seq_divider_32by16_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW:0]   r_in,
  input  logic          next_bit,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW+1:0] t_wide;
  logic [DW:0]   diff;
  logic          ge;

  // The full-width trial keeps r_in[DW] in the compare; it is always zero
  // because the running remainder stays below the divisor.
  assign t_wide = {r_in, next_bit};
  assign ge     = (t_wide >= {2'b00, divisor});
  // t_wide < 2*divisor, so the difference fits in DW+1 bits when ge is set.
  assign diff   = t_wide[DW:0] - {1'b0, divisor};

  assign r_next = ge ? diff : t_wide[DW:0];
  assign q_bit  = ge;

endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider: 2*DW-bit dividend / DW-bit divisor.
// One operation in flight, valid/ready handshake on operands and result.
// SKIP_LSB low quotient bits are not computed (forced 0), saving that many
// iterations; the remainder is then that of (dividend >> SKIP_LSB).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : slave side of seq_divider_32by16_if (operands in, result out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_RUN  | one restoring iteration per cycle, N = DW-SKIP_LSB of them
//   ST_DONE | result registered, out_valid held until out_ready
module seq_divider_32by16
  import seq_divider_32by16_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int SKIP_LSB = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_divider_32by16_if.slave    bus
);

  localparam int            N_ITER   = iter_count(DW, SKIP_LSB);
  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_ITER - 1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [DW:0]   r_q;
  logic [DW-1:0] lo_sr;
  logic [DW-1:0] q_sr;
  logic [DW-1:0] divisor_q;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic          dbz_q;
  logic          ovf_q;

  logic [DW:0]   r_next;
  logic          q_bit;
  logic [DW-1:0] q_shifted;
  logic          accept;

  div_restore_step #(.DW(DW)) u_step (
    .r_in     (r_q),
    .next_bit (lo_sr[DW-1]),
    .divisor  (divisor_q),
    .r_next   (r_next),
    .q_bit    (q_bit)
  );

  assign q_shifted = {q_sr[DW-2:0], q_bit};
  assign accept    = bus.in_valid & in_ready_q;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r_q         <= '0;
      lo_sr       <= '0;
      q_sr        <= '0;
      divisor_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // in_ready comes up one cycle after reset release.
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            divisor_q  <= bus.divisor;
            lo_sr      <= bus.dividend[DW-1:0];
            r_q        <= {1'b0, bus.dividend[2*DW-1:DW]};
            q_sr       <= '0;
            cnt        <= CNT_LOAD;
            if (bus.divisor == '0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              quotient_q  <= '1;
              remainder_q <= bus.dividend[DW-1:0];
            end else if (bus.dividend[2*DW-1:DW] >= bus.divisor) begin
              // Quotient would need more than DW bits.
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.dividend[DW-1:0];
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          r_q   <= r_next;
          lo_sr <= {lo_sr[DW-2:0], 1'b0};
          q_sr  <= q_shifted;
          cnt   <= cnt - CW'(1);
          // Last iteration loads the result directly so out_valid rises
          // N+1 edges after the accept edge (accept edge included).
          if (cnt == '0) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= q_shifted << SKIP_LSB;
            remainder_q <= r_next[DW-1:0];
          end
        end

        ST_DONE: begin
          // Result handshake returns to IDLE; no accept can happen in this
          // same cycle because in_ready is still low.
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32by16.sv
module tb_seq_divider_32by16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_divider_32by16_if #(.DW(16)) bus0 ();
  seq_divider_32by16_if #(.DW(16)) bus1 ();

  // Both DUTs see identical operands and out_ready; bus1 drives the SKIP_LSB=4 copy.
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.dividend  = bus0.dividend;
  assign bus1.divisor   = bus0.divisor;
  assign bus1.out_ready = bus0.out_ready;

  seq_divider_32by16 #(.DW(16), .SKIP_LSB(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq_divider_32by16 #(.DW(16), .SKIP_LSB(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  logic [15:0] q0, r0, q1, r1;
  logic        dbz0, ovf0, dbz1, ovf1;
  int          lat0, lat1;

  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the divider's definition.
  function automatic void model(input logic [31:0] dd, input logic [15:0] dv, input int s,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dbz, output logic ovf, output int lat);
    longint unsigned num;
    dbz = 1'b0;
    ovf = 1'b0;
    lat = 1;
    if (dv == 16'd0) begin
      dbz = 1'b1;
      q   = 16'hFFFF;
      r   = dd[15:0];
    end else if (dd[31:16] >= dv) begin
      ovf = 1'b1;
      q   = 16'hFFFF;
      r   = dd[15:0];
    end else begin
      num = longint'(dd) >> s;
      q   = 16'((num / longint'(dv)) << s);
      r   = 16'(num % longint'(dv));
      lat = 16 - s + 1;
    end
  endfunction

  task automatic start_op(input logic [31:0] dd, input logic [15:0] dv);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.in_ready) chk("in_ready_timeout", 64'(bus0.in_ready), 64'd1);
    bus0.dividend = dd;
    bus0.divisor  = dv;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges (accept edge = 1).
  task automatic wait_result();
    int n;
    n    = 0;
    lat0 = 1;
    lat1 = 0;
    @(negedge clk);
    while (n < 60) begin
      if (bus1.out_valid && lat1 == 0) lat1 = lat0;
      if (bus0.out_valid) break;
      @(posedge clk);
      lat0++;
      @(negedge clk);
      n++;
    end
    if (!bus0.out_valid) chk("out_valid_timeout", 64'(bus0.out_valid), 64'd1);
    q0 = bus0.quotient;  r0 = bus0.remainder; dbz0 = bus0.div_by_zero; ovf0 = bus0.overflow;
    q1 = bus1.quotient;  r1 = bus1.remainder; dbz1 = bus1.div_by_zero; ovf1 = bus1.overflow;
  endtask

  task automatic handshake();
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1 bus0.out_ready = 1'b0;
  endtask

  task automatic chk_skip(input string name, input logic [31:0] dd, input logic [15:0] dv);
    logic [15:0] mq, mr;
    logic        md, mo;
    int          ml;
    model(dd, dv, 4, mq, mr, md, mo, ml);
    chk({name, "_skip_res"}, 64'({q1, r1, dbz1, ovf1}), 64'({mq, mr, md, mo}));
    chk({name, "_skip_lat"}, 64'(lat1), 64'(ml));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_dut0"}, 64'({bus0.in_ready, bus0.out_valid, bus0.quotient, bus0.remainder,
                              bus0.div_by_zero, bus0.overflow}), 64'd0);
    chk({name, "_dut1"}, 64'({bus1.in_ready, bus1.out_valid, bus1.quotient, bus1.remainder,
                              bus1.div_by_zero, bus1.overflow}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mq, mr, dv, hi;
    logic        md, mo;
    logic [31:0] dd;
    int          ml;
    logic        seen;

    vecs[0] = '{32'd1000,       16'd7,      16'd142,    16'd6,      1'b0, 1'b0};
    vecs[1] = '{32'h1234_5678,  16'd0,      16'hFFFF,   16'h5678,   1'b1, 1'b0};
    vecs[2] = '{32'h0001_0000,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b1};
    vecs[3] = '{32'hFFFE_0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0};
    vecs[4] = '{32'd100,        16'd10,     16'd10,     16'd0,      1'b0, 1'b0};
    vecs[5] = '{32'd0,          16'd5,      16'd0,      16'd0,      1'b0, 1'b0};
    vecs[6] = '{32'h0000_FFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0};
    vecs[7] = '{32'h0005_0000,  16'd5,      16'hFFFF,   16'd0,      1'b0, 1'b1};
    vecs[8] = '{32'h0004_FFFF,  16'd5,      16'hFFFF,   16'd4,      1'b0, 1'b0};
    vecs[9] = '{32'h0000_0000,  16'd0,      16'hFFFF,   16'd0,      1'b1, 1'b0};

    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.dividend  = '0;
    bus0.divisor   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", 64'(bus0.in_ready), 64'd1);

    // Directed table
    foreach (vecs[i]) begin
      start_op(vecs[i].dd, vecs[i].dv);
      wait_result();
      chk($sformatf("vec%0d_q", i),     64'(q0),   64'(vecs[i].q));
      chk($sformatf("vec%0d_r", i),     64'(r0),   64'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i),   64'(dbz0), 64'(vecs[i].dbz));
      chk($sformatf("vec%0d_ovf", i),   64'(ovf0), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_lat", i),   64'(lat0),
          (vecs[i].dbz || vecs[i].ovf) ? 64'd1 : 64'd17);
      chk_skip($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv);
      handshake();
    end

    // Truncated quotient, hand values
    start_op(32'd1000, 16'd7);
    wait_result();
    chk("skip4_q",   64'(q1),   64'd128);
    chk("skip4_r",   64'(r1),   64'd6);
    chk("skip4_lat", 64'(lat1), 64'd13);
    handshake();

    // Backpressure: result held, new operands ignored, then accepted after handshake
    start_op(32'd1000, 16'd7);
    wait_result();
    bus0.dividend = 32'd100;
    bus0.divisor  = 16'd10;
    bus0.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_dut0", 64'({bus0.out_valid, bus0.in_ready, bus0.quotient, bus0.remainder}),
          64'({1'b1, 1'b0, 16'd142, 16'd6}));
      chk("hold_dut1", 64'({bus1.out_valid, bus1.in_ready, bus1.quotient, bus1.remainder}),
          64'({1'b1, 1'b0, 16'd128, 16'd6}));
    end
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1 bus0.out_ready = 1'b0;
    @(negedge clk);
    chk("post_handshake_idle", 64'({bus0.out_valid, bus0.in_ready, bus0.quotient}),
        64'({1'b0, 1'b1, 16'd142}));
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    wait_result();
    chk("held_op_q",   64'(q0),   64'd10);
    chk("held_op_r",   64'(r0),   64'd0);
    chk("held_op_lat", 64'(lat0), 64'd17);
    chk_skip("held_op", 32'd100, 16'd10);
    handshake();

    // Reset in the middle of an operation
    start_op(32'd1000, 16'd7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      seen = seen | bus0.out_valid | bus1.out_valid;
    end
    chk("aborted_no_valid", 64'(seen), 64'd0);
    start_op(32'd100, 16'd10);
    wait_result();
    chk("after_reset_q", 64'(q0), 64'd10);
    chk("after_reset_r", 64'(r0), 64'd0);
    handshake();

    // Random non-special operands
    for (int n = 0; n < 1500; n++) begin
      dv = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      hi = 16'($urandom % 32'(dv));
      dd = {hi, 16'($urandom)};
      start_op(dd, dv);
      wait_result();
      model(dd, dv, 0, mq, mr, md, mo, ml);
      chk("rand_dut0", 64'({q0, r0, dbz0, ovf0, 8'(lat0)}), 64'({mq, mr, md, mo, 8'(ml)}));
      chk("rand_identity", 64'(q0) * 64'(dv) + 64'(r0), 64'(dd));
      model(dd, dv, 4, mq, mr, md, mo, ml);
      chk("rand_dut1", 64'({q1, r1, dbz1, ovf1, 8'(lat1)}), 64'({mq, mr, md, mo, 8'(ml)}));
      handshake();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
